// File: rtl/nw_fill_scheduler.sv
// -----------------------------------------------------------------------------
// nw_fill_scheduler
//
// Sequences the Needleman-Wunsch score-matrix fill over a single-port score RAM.
// The matrix is (N+1)x(N+1) and is stored row-major at address i*(N+1)+j.
//
// A fill runs in two phases:
//   1. INIT writes the boundary row 0 and column 0 with -(k*GAP) over 2N+1
//      cycles.
//   2. Each interior cell (i,j) is visited row-major from (1,1) to (N,N):
//        a. Read diag, up and left from the RAM.
//        b. Present them to the external cell calculator.
//        c. Wait for the calculator's result.
//        d. Write the result back to (i,j).
//
// Optional build macro: NW_FILL_PERF_EN adds two 32-bit saturating counters:
//   perf_cycles - cycles spent busy
//   perf_stall  - cycles spent waiting on the calculator
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous, active-low reset
//   start       in   1-cycle fill request, ignored while busy
//   ram_addr    out  score RAM address (0 when no access is in progress)
//   ram_we      out  score RAM write enable
//   ram_wdata   out  score RAM write data
//   ram_rdata   in   score RAM read data, valid 1 cycle after ram_addr
//   calc_i      out  current row index
//   calc_j      out  current column index
//   calc_start  out  1-cycle pulse; neighbours valid with it
//   nb_diag     out  score(i-1,j-1)
//   nb_up       out  score(i-1,j)
//   nb_left     out  score(i,j-1)
//   res_valid   in   calculator result strobe (only honoured while waiting)
//   res_score   in   calculator result
//   busy        out  high from INIT through the last cell write
//   done        out  high once the fill has completed, until the next start
//   perf_cycles out  (NW_FILL_PERF_EN only) busy cycle count
//   perf_stall  out  (NW_FILL_PERF_EN only) calculator wait cycle count
// -----------------------------------------------------------------------------
module nw_fill_scheduler #(
    parameter int N       = 8,
    parameter int ADDR_W  = 7,
    parameter int SCORE_W = 8,
    parameter int IDX_W   = 4,
    parameter int GAP     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [SCORE_W-1:0] ram_wdata,
    input  logic [SCORE_W-1:0] ram_rdata,
    output logic [IDX_W-1:0]   calc_i,
    output logic [IDX_W-1:0]   calc_j,
    output logic               calc_start,
    output logic [SCORE_W-1:0] nb_diag,
    output logic [SCORE_W-1:0] nb_up,
    output logic [SCORE_W-1:0] nb_left,
    input  logic               res_valid,
    input  logic [SCORE_W-1:0] res_score,
    output logic               busy,
    output logic               done
`ifdef NW_FILL_PERF_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_stall
`endif
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_RD_D,
        ST_RD_U,
        ST_RD_L,
        ST_CAPT,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // The INIT step counter must reach 2N, one bit wider than a matrix index.
    localparam int K_W = IDX_W + 1;

    localparam logic [IDX_W-1:0]  ZERO_IDX = '0;
    localparam logic [IDX_W-1:0]  ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  N_IDX    = IDX_W'(N);
    localparam logic [K_W-1:0]    ONE_K    = K_W'(1);
    localparam logic [K_W-1:0]    N_K      = K_W'(N);
    localparam logic [K_W-1:0]    LAST_K   = K_W'(2 * N);
    localparam logic [ADDR_W-1:0] ROW_LEN  = ADDR_W'(N + 1);

    // Row-major address of (row, col), unsigned at ADDR_W.
    function automatic logic [ADDR_W-1:0] cell_addr(
        input logic [IDX_W-1:0] row,
        input logic [IDX_W-1:0] col
    );
        return ADDR_W'(row) * ROW_LEN + ADDR_W'(col);
    endfunction

    // Boundary score -(k*GAP), truncated to SCORE_W.
    function automatic logic [SCORE_W-1:0] gap_score(
        input logic [IDX_W-1:0] k
    );
        return SCORE_W'(-(int'(k) * GAP));
    endfunction

    // INIT step k: steps 0..N cover row 0 (col = k);
    // steps N+1..2N cover column 0 (row = k-N).
    function automatic logic [IDX_W-1:0] init_row(input logic [K_W-1:0] k);
        return (k <= N_K) ? ZERO_IDX : IDX_W'(k - N_K);
    endfunction

    function automatic logic [IDX_W-1:0] init_col(input logic [K_W-1:0] k);
        return (k <= N_K) ? IDX_W'(k) : ZERO_IDX;
    endfunction

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t             state_reg;
    logic [K_W-1:0]     k_reg;
    logic [IDX_W-1:0]   i_reg;
    logic [IDX_W-1:0]   j_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               we_reg;
    logic [SCORE_W-1:0] wdata_reg;
    logic               calc_start_reg;
    logic [SCORE_W-1:0] nb_diag_reg;
    logic [SCORE_W-1:0] nb_up_reg;
    logic [SCORE_W-1:0] nb_left_reg;
    logic               busy_reg;
    logic               done_reg;

    // Derived step values used by the FSM
    logic [K_W-1:0]     k_next;
    logic [IDX_W-1:0]   i_dec;
    logic [IDX_W-1:0]   j_dec;
    logic [IDX_W-1:0]   i_inc;
    logic [IDX_W-1:0]   j_inc;
    logic [IDX_W-1:0]   init_row_next;
    logic [IDX_W-1:0]   init_col_next;
    logic               start_accept;
    logic               last_cell;

    assign k_next        = k_reg + ONE_K;
    assign i_dec         = i_reg - ONE_IDX;
    assign j_dec         = j_reg - ONE_IDX;
    assign i_inc         = i_reg + ONE_IDX;
    assign j_inc         = j_reg + ONE_IDX;
    assign init_row_next = init_row(k_next);
    assign init_col_next = init_col(k_next);

    // start is only honoured when no fill is in progress.
    assign start_accept  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign last_cell     = (i_reg == N_IDX) && (j_reg == N_IDX);

    // Outputs are loaded on the edge that enters the state they belong to,
    // so ram_addr/ram_we/ram_wdata are valid for the whole cycle of that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            k_reg          <= '0;
            i_reg          <= '0;
            j_reg          <= '0;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            calc_start_reg <= 1'b0;
            nb_diag_reg    <= '0;
            nb_up_reg      <= '0;
            nb_left_reg    <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            calc_start_reg <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    // res_valid is deliberately not looked at here;
                    // a start in DONE always wins.
                    if (start_accept) begin
                        state_reg <= ST_INIT;
                        k_reg     <= '0;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        addr_reg  <= '0;          // step 0: (0,0)
                        wdata_reg <= '0;          // -(0*GAP)
                        we_reg    <= 1'b1;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                    end
                end

                ST_INIT: begin
                    if (k_reg == LAST_K) begin
                        // Boundary complete; first cell is (1,1),
                        // whose diagonal is (0,0).
                        state_reg <= ST_RD_D;
                        we_reg    <= 1'b0;
                        wdata_reg <= '0;
                        i_reg     <= ONE_IDX;
                        j_reg     <= ONE_IDX;
                        addr_reg  <= '0;
                    end else begin
                        k_reg     <= k_next;
                        addr_reg  <= cell_addr(init_row_next, init_col_next);
                        // Exactly one of row/col is non-zero on the boundary.
                        wdata_reg <= gap_score(init_row_next + init_col_next);
                    end
                end

                ST_RD_D: begin
                    state_reg <= ST_RD_U;
                    addr_reg  <= cell_addr(i_dec, j_reg);   // up
                end

                ST_RD_U: begin
                    state_reg   <= ST_RD_L;
                    nb_diag_reg <= ram_rdata;
                    addr_reg    <= cell_addr(i_reg, j_dec); // left
                end

                ST_RD_L: begin
                    state_reg      <= ST_CAPT;
                    nb_up_reg      <= ram_rdata;
                    addr_reg       <= '0;
                    calc_start_reg <= 1'b1;                 // high during CAPT
                end

                ST_CAPT: begin
                    state_reg   <= ST_WAIT;
                    nb_left_reg <= ram_rdata;
                end

                ST_WAIT: begin
                    if (res_valid) begin
                        state_reg <= ST_WRITE;
                        we_reg    <= 1'b1;
                        addr_reg  <= cell_addr(i_reg, j_reg);
                        wdata_reg <= res_score;
                    end
                end

                ST_WRITE: begin
                    we_reg    <= 1'b0;
                    wdata_reg <= '0;
                    if (last_cell) begin
                        state_reg <= ST_DONE;
                        addr_reg  <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (j_reg == N_IDX) begin
                        // Next cell is (i+1,1); its diagonal is (i,0).
                        state_reg <= ST_RD_D;
                        i_reg     <= i_inc;
                        j_reg     <= ONE_IDX;
                        addr_reg  <= cell_addr(i_reg, ZERO_IDX);
                    end else begin
                        // Next cell is (i,j+1); its diagonal is (i-1,j).
                        state_reg <= ST_RD_D;
                        j_reg     <= j_inc;
                        addr_reg  <= cell_addr(i_dec, j_reg);
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    we_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    assign ram_addr   = addr_reg;
    assign ram_we     = we_reg;
    assign ram_wdata  = wdata_reg;
    assign calc_i     = i_reg;
    assign calc_j     = j_reg;
    assign calc_start = calc_start_reg;
    assign nb_diag    = nb_diag_reg;
    assign nb_up      = nb_up_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

    // The left read returns during CAPT, the same cycle calc_start is high,
    // so the RAM data is forwarded directly in CAPT.
    // From WAIT onwards the captured copy holds the value steady.
    assign nb_left = (state_reg == ST_CAPT) ? ram_rdata : nb_left_reg;

`ifdef NW_FILL_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters: clear on an accepted start,
    // count busy / WAIT cycles, saturate at all-ones.
    // -------------------------------------------------------------------------
    logic [31:0] perf_cycles_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles_reg <= '0;
            perf_stall_reg  <= '0;
        end else if (start_accept) begin
            perf_cycles_reg <= '0;
            perf_stall_reg  <= '0;
        end else begin
            if (busy_reg && (perf_cycles_reg != '1)) begin
                perf_cycles_reg <= perf_cycles_reg + 32'd1;
            end
            if ((state_reg == ST_WAIT) && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_reg;
    assign perf_stall  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_nw_fill_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nw_fill_scheduler
//
// Scoreboard bench for nw_fill_scheduler with N=2, GAP=2.
//
// Expected RAM writes and expected neighbour sets are pushed to queues when a
// fill is started. They are popped as the DUT writes the RAM or pulses
// calc_start.
//
// The calculator model returns diag+1 after a programmable latency.
// -----------------------------------------------------------------------------
module tb_nw_fill_scheduler;

    localparam int TN      = 2;
    localparam int TADDR_W = 7;
    localparam int TSCORE  = 8;
    localparam int TIDX_W  = 4;
    localparam int TGAP    = 2;

    typedef struct {
        logic [TADDR_W-1:0] addr;
        logic [TSCORE-1:0]  data;
    } wr_t;

    typedef struct {
        int                i;
        int                j;
        logic [TSCORE-1:0] d;
        logic [TSCORE-1:0] u;
        logic [TSCORE-1:0] l;
    } nb_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [TADDR_W-1:0]  ram_addr;
    logic                ram_we;
    logic [TSCORE-1:0]   ram_wdata;
    logic [TSCORE-1:0]   ram_rdata = '0;
    logic [TIDX_W-1:0]   calc_i;
    logic [TIDX_W-1:0]   calc_j;
    logic                calc_start;
    logic [TSCORE-1:0]   nb_diag;
    logic [TSCORE-1:0]   nb_up;
    logic [TSCORE-1:0]   nb_left;
    logic                res_valid = 1'b0;
    logic [TSCORE-1:0]   res_score = '0;
    logic                busy;
    logic                done;
`ifdef NW_FILL_PERF_EN
    logic [31:0]         perf_cycles;
    logic [31:0]         perf_stall;
`endif

    nw_fill_scheduler #(
        .N       (TN),
        .ADDR_W  (TADDR_W),
        .SCORE_W (TSCORE),
        .IDX_W   (TIDX_W),
        .GAP     (TGAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .calc_i     (calc_i),
        .calc_j     (calc_j),
        .calc_start (calc_start),
        .nb_diag    (nb_diag),
        .nb_up      (nb_up),
        .nb_left    (nb_left),
        .res_valid  (res_valid),
        .res_score  (res_score),
        .busy       (busy),
        .done       (done)
`ifdef NW_FILL_PERF_EN
        ,
        .perf_cycles(perf_cycles),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_wr[$];
    nb_t exp_nb[$];

    // Calculator model state
    int                calc_lat = 1;
    logic              pend     = 1'b0;
    int                cnt      = 0;
    logic [TSCORE-1:0] op       = '0;
    nb_t               cur;
    logic              spur_en  = 1'b0;
    logic              spur_arm = 1'b0;
    logic              we_prev  = 1'b0;
    int                busy_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model of one full fill with the diag+1 calculator.
    task automatic push_run();
        logic [TSCORE-1:0] sc [0:TN][0:TN];
        for (int j = 0; j <= TN; j++) begin
            sc[0][j] = TSCORE'(-(j * TGAP));
            exp_wr.push_back('{addr: TADDR_W'(j), data: sc[0][j]});
        end
        for (int i = 1; i <= TN; i++) begin
            sc[i][0] = TSCORE'(-(i * TGAP));
            exp_wr.push_back('{addr: TADDR_W'(i * (TN + 1)), data: sc[i][0]});
        end
        for (int i = 1; i <= TN; i++) begin
            for (int j = 1; j <= TN; j++) begin
                sc[i][j] = sc[i-1][j-1] + 8'd1;
                exp_nb.push_back('{i: i, j: j, d: sc[i-1][j-1], u: sc[i-1][j], l: sc[i][j-1]});
                exp_wr.push_back('{addr: TADDR_W'(i * (TN + 1) + j), data: sc[i][j]});
            end
        end
    endtask

    // Score RAM: synchronous read, read-before-write.
    logic [TSCORE-1:0] mem [0:(1<<TADDR_W)-1];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Write monitor and scoreboard
    always @(negedge clk) begin
        if (busy) begin
            busy_cnt++;
        end
        if (ram_we) begin
            if (exp_wr.size() == 0) begin
                check_val("unexpected_write", 32'(ram_addr), 32'hFFFF);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                $display("wr addr=%0d data=%0d", ram_addr, $signed(ram_wdata));
                check_val("wr_addr", 32'(ram_addr), 32'(e.addr));
                check_val("wr_data", 32'(ram_wdata), 32'(e.data));
            end
        end
    end

    // Calculator model: returns diag+1 after calc_lat cycles.
    // It can optionally inject a spurious res_valid in RD_U
    // (the second cycle after any write).
    always @(negedge clk) begin
        res_valid = 1'b0;
        res_score = '0;
        if (spur_arm) begin
            res_valid = 1'b1;
            res_score = 8'h55;
            spur_arm  = 1'b0;
        end
        if (spur_en && we_prev && !ram_we) begin
            spur_arm = 1'b1;
        end
        we_prev = ram_we;

        if (pend) begin
            check_val("hold_i", 32'(calc_i), 32'(cur.i));
            check_val("hold_j", 32'(calc_j), 32'(cur.j));
            check_val("hold_diag", 32'(nb_diag), 32'(cur.d));
            check_val("hold_up", 32'(nb_up), 32'(cur.u));
            check_val("hold_left", 32'(nb_left), 32'(cur.l));
            if (cnt <= 1) begin
                res_valid = 1'b1;
                res_score = op + 8'd1;
                pend      = 1'b0;
            end else begin
                cnt--;
            end
        end

        if (calc_start) begin
            if (exp_nb.size() == 0) begin
                check_val("unexpected_calc_start", 32'd1, 32'd0);
            end else begin
                cur = exp_nb.pop_front();
                $display("cell i=%0d j=%0d diag=%0d up=%0d left=%0d",
                         calc_i, calc_j, $signed(nb_diag), $signed(nb_up), $signed(nb_left));
                check_val("calc_i", 32'(calc_i), 32'(cur.i));
                check_val("calc_j", 32'(calc_j), 32'(cur.j));
                check_val("nb_diag", 32'(nb_diag), 32'(cur.d));
                check_val("nb_up", 32'(nb_up), 32'(cur.u));
                check_val("nb_left", 32'(nb_left), 32'(cur.l));
            end
            pend = 1'b1;
            cnt  = calc_lat;
            op   = nb_diag;
        end
    end

    task automatic wait_done(input int budget, input int exp_busy, input int exp_stall);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_val("done_reached", 32'(done), 32'd1);
        check_val("busy_after_done", 32'(busy), 32'd0);
        check_val("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        check_val("writes_left", 32'(exp_wr.size()), 32'd0);
        check_val("cells_left", 32'(exp_nb.size()), 32'd0);
`ifdef NW_FILL_PERF_EN
        check_val("perf_cycles", perf_cycles, 32'(exp_busy));
        check_val("perf_stall", perf_stall, 32'(exp_stall));
`else
        if (exp_stall < 0) begin
            $display("note: negative stall expectation");
        end
`endif
    endtask

    task automatic launch();
        @(negedge clk);
        #1;
        push_run();
        busy_cnt = 0;
        start    = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        check_val("busy_after_start", 32'(busy), 32'd1);
        check_val("done_after_start", 32'(done), 32'd0);
    endtask

    initial begin
        int c;
        rst   = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_we", 32'(ram_we), 32'd0);
        check_val("rst_calc_start", 32'(calc_start), 32'd0);
        #1;
        start = 1'b0;
        rst   = 1'b1;

        // Run A: latency 1, with a start pulse in the middle of the fill.
        calc_lat = 1;
        launch();
        repeat (10) @(negedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(400, 29, 4);

        // Run B: restart from DONE with start and res_valid coincident.
        // Latency 5, with spurious res_valid in RD_U.
        calc_lat = 5;
        spur_en  = 1'b1;
        @(negedge clk);
        #1;
        push_run();
        busy_cnt  = 0;
        start     = 1'b1;
        res_valid = 1'b1;
        res_score = 8'h77;
        @(negedge clk);
        #1;
        start = 1'b0;
        check_val("restart_done_clear", 32'(done), 32'd0);
        check_val("restart_busy", 32'(busy), 32'd1);
        wait_done(600, 45, 20);
        spur_en = 1'b0;

        // Run C: reset while waiting on cell (1,2); no further writes allowed.
        calc_lat = 8;
        launch();
        c = 0;
        while (!(pend && cur.i == 1 && cur.j == 2) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check_val("abort_reached", 32'(c < 200), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        check_val("abort_writes_pending", 32'(exp_wr.size()), 32'd3);
        exp_wr.delete();
        exp_nb.delete();
        pend = 1'b0;
        repeat (3) @(negedge clk);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_we", 32'(ram_we), 32'd0);
        #1;
        rst = 1'b1;

        // Run D: fresh fill after the abort starts again from address 0.
        calc_lat = 1;
        launch();
        wait_done(400, 29, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
